// File: rtl/led_blink_pkg.sv
// Shared encodings and helpers for the led_blink_seq LED sequencer.
// Mode and FSM state constants stay plain localparams so older code that
// compares against raw bit patterns keeps working.
package led_blink_pkg;

    // Blink modes, matching the 2-bit cfg_mode field.
    localparam logic [1:0] MODE_BLINK      = 2'd0;
    localparam logic [1:0] MODE_STEADY_ON  = 2'd1;
    localparam logic [1:0] MODE_STEADY_OFF = 2'd2;
    localparam logic [1:0] MODE_ROTATE     = 2'd3;

    // Phase FSM states. ST_ON is 1 so phase_on is simply the state bit.
    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_ON  = 1'b1;

    // Widest LED vector the rotate helper handles.
    localparam int LED_MAX = 64;

    // Rotate the low w bits of v left by one: bit w-1 wraps to bit 0.
    // Bits at and above w must be zero on entry and are zero on exit.
    function automatic logic [LED_MAX-1:0] rotl1(input logic [LED_MAX-1:0] v,
                                                 input int unsigned        w);
        logic [LED_MAX-1:0] mask;
        mask = (LED_MAX'(1) << w) - LED_MAX'(1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    // STEADY_* modes freeze the phase machine.
    function automatic logic is_steady(input logic [1:0] m);
        return (m == MODE_STEADY_ON) || (m == MODE_STEADY_OFF);
    endfunction

endpackage

// File: rtl/led_blink_cfg_slot.sv
// Single-entry pending-config slot for led_blink_seq.
// Holds one accepted config until the phase machine can take it
// (next OFF->ON boundary, or immediately when the active mode is steady).
// A transfer that lands exactly on a boundary skips the slot entirely.
module led_blink_cfg_slot
    import led_blink_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_on_cyc,
    input  logic [CNT_W-1:0]  cfg_off_cyc,
    input  logic [N_LEDS-1:0] cfg_pattern,
    input  logic [1:0]        cfg_mode,
    input  logic              boundary_i,     // OFF->ON edge happens at the coming clk edge
    input  logic              steady_i,       // active mode is STEADY_ON/STEADY_OFF
    output logic              load_o,         // phase machine must load new_* this edge
    output logic              bypass_o,       // load comes straight from the cfg port
    output logic [CNT_W-1:0]  new_on_o,
    output logic [CNT_W-1:0]  new_off_o,
    output logic [N_LEDS-1:0] new_pattern_o,
    output logic [1:0]        new_mode_o
);

    // A zero length would make the counter compare underflow; treat it as 1.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    logic              pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]  pend_on_q;
    logic [CNT_W-1:0]  pend_off_q;
    logic [N_LEDS-1:0] pend_pattern_q;
    logic [1:0]        pend_mode_q;

    logic take;
    logic capture;
    logic apply;

    assign cfg_ready = ~pend_valid_q;
    assign take      = cfg_valid & cfg_ready;
    assign bypass_o  = take & boundary_i;
    assign capture   = take & ~boundary_i;
    assign apply     = pend_valid_q & (boundary_i | steady_i);
    assign load_o    = bypass_o | apply;

    assign new_on_o      = bypass_o ? clamp_len(cfg_on_cyc)  : pend_on_q;
    assign new_off_o     = bypass_o ? clamp_len(cfg_off_cyc) : pend_off_q;
    assign new_pattern_o = bypass_o ? cfg_pattern            : pend_pattern_q;
    assign new_mode_o    = bypass_o ? cfg_mode               : pend_mode_q;

    // Slot occupancy: set on capture, cleared when the phase machine takes it.
    always_comb begin
        pend_valid_d = pend_valid_q;
        if (capture) begin
            pend_valid_d = 1'b1;
        end else if (apply) begin
            pend_valid_d = 1'b0;
        end
    end

    // Occupancy flag; reset drops any waiting config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
        end
    end

    // Pending fields, stored already clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_on_q      <= CNT_W'(1);
            pend_off_q     <= CNT_W'(1);
            pend_pattern_q <= '0;
            pend_mode_q    <= MODE_BLINK;
        end else if (capture) begin
            pend_on_q      <= clamp_len(cfg_on_cyc);
            pend_off_q     <= clamp_len(cfg_off_cyc);
            pend_pattern_q <= cfg_pattern;
            pend_mode_q    <= cfg_mode;
        end
    end

endmodule

// File: rtl/led_blink_seq.sv
// Runtime-programmable LED blinker.
// Drives N_LEDS outputs through ON/OFF phases with reprogrammable lengths,
// pattern and mode. New config takes effect only at an OFF->ON boundary
// (or at once in steady modes), so the LEDs never show a partial period.
// Build option: define BLINK_DIM_EN to add an 8-bit 'duty' input that
// PWM-dims the pattern during ON.
module led_blink_seq
    import led_blink_pkg::*;
#(
    parameter int                CLK_FREQ    = 25_000_000,
    parameter int                N_LEDS      = 8,            // must not exceed LED_MAX
    parameter int                CNT_W       = 32,
    parameter logic [CNT_W-1:0]  DEF_ON_CYC  = CNT_W'(CLK_FREQ * 4),
    parameter logic [CNT_W-1:0]  DEF_OFF_CYC = CNT_W'(CLK_FREQ * 2),
    parameter logic [N_LEDS-1:0] DEF_PATTERN = N_LEDS'(8'h55)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_on_cyc,
    input  logic [CNT_W-1:0]  cfg_off_cyc,
    input  logic [N_LEDS-1:0] cfg_pattern,
    input  logic [1:0]        cfg_mode,
    output logic [N_LEDS-1:0] leds,
    output logic              phase_on,
    output logic              period_done
`ifdef BLINK_DIM_EN
    ,
    input  logic [7:0]        duty
`endif
);

    localparam logic [CNT_W-1:0] DEF_ON_LEN  = (DEF_ON_CYC  == '0) ? CNT_W'(1) : DEF_ON_CYC;
    localparam logic [CNT_W-1:0] DEF_OFF_LEN = (DEF_OFF_CYC == '0) ? CNT_W'(1) : DEF_OFF_CYC;

    logic [0:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [CNT_W-1:0]  on_len_q,  on_len_d;
    logic [CNT_W-1:0]  off_len_q, off_len_d;
    logic [N_LEDS-1:0] pat_q,     pat_d;
    logic [1:0]        mode_q,    mode_d;
    logic [N_LEDS-1:0] leds_q,    leds_d;
    logic              pd_q,      pd_d;

    logic              blink_run;
    logic [CNT_W-1:0]  cur_len;
    logic              last_cyc;
    logic              boundary;
    logic [N_LEDS-1:0] pat_rot;
    logic [N_LEDS-1:0] dim_mask;

    logic              slot_load;
    logic              slot_bypass;
    logic [CNT_W-1:0]  new_on;
    logic [CNT_W-1:0]  new_off;
    logic [N_LEDS-1:0] new_pattern;
    logic [1:0]        new_mode;

    assign blink_run = ~is_steady(mode_q);
    assign cur_len   = (state_q == ST_ON) ? on_len_q : off_len_q;
    assign last_cyc  = (cnt_q == cur_len - CNT_W'(1));
    assign boundary  = blink_run & (state_q == ST_OFF) & last_cyc;
    assign pat_rot   = N_LEDS'(rotl1(LED_MAX'(pat_q), N_LEDS));

`ifdef BLINK_DIM_EN
    logic [7:0] pwm_q;

    // Free-running PWM counter for dimming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 8'd0;
        end else begin
            pwm_q <= pwm_q + 8'd1;
        end
    end

    assign dim_mask = {N_LEDS{pwm_q < duty}};
`else
    assign dim_mask = '1;
`endif

    led_blink_cfg_slot #(
        .N_LEDS (N_LEDS),
        .CNT_W  (CNT_W)
    ) u_cfg_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_on_cyc    (cfg_on_cyc),
        .cfg_off_cyc   (cfg_off_cyc),
        .cfg_pattern   (cfg_pattern),
        .cfg_mode      (cfg_mode),
        .boundary_i    (boundary),
        .steady_i      (~blink_run),
        .load_o        (slot_load),
        .bypass_o      (slot_bypass),
        .new_on_o      (new_on),
        .new_off_o     (new_off),
        .new_pattern_o (new_pattern),
        .new_mode_o    (new_mode)
    );

    // Phase machine next state: config load, steady hold, or normal ON/OFF stepping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        pat_d     = pat_q;
        mode_d    = mode_q;
        pd_d      = 1'b0;

        if (slot_load) begin
            // A load restarts a fresh ON phase; it counts as a period end
            // only when it lands on a real OFF->ON boundary.
            mode_d    = new_mode;
            on_len_d  = new_on;
            off_len_d = new_off;
            pat_d     = new_pattern;
            cnt_d     = '0;
            state_d   = ST_ON;
            pd_d      = boundary;
        end else if (!blink_run) begin
            cnt_d   = '0;
            state_d = ST_ON;
        end else if (last_cyc) begin
            cnt_d = '0;
            if (state_q == ST_ON) begin
                state_d = ST_OFF;
                if (mode_q == MODE_ROTATE) begin
                    pat_d = pat_rot;
                end
            end else begin
                state_d = ST_ON;
                pd_d    = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // LEDs follow the next state so they change on the same edge as the phase.
        leds_d = ((state_d == ST_ON) && (mode_d != MODE_STEADY_OFF)) ? (pat_d & dim_mask) : '0;
    end

    // Phase machine and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ON;
            cnt_q     <= '0;
            on_len_q  <= DEF_ON_LEN;
            off_len_q <= DEF_OFF_LEN;
            pat_q     <= DEF_PATTERN;
            mode_q    <= MODE_BLINK;
            leds_q    <= DEF_PATTERN;
            pd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            pat_q     <= pat_d;
            mode_q    <= mode_d;
            leds_q    <= leds_d;
            pd_q      <= pd_d;
        end
    end

    assign leds        = leds_q;
    assign phase_on    = (state_q == ST_ON);
    assign period_done = pd_q;

    // Bypass only matters inside the slot; kept visible here for debug probes.
    logic unused_bypass;
    assign unused_bypass = slot_bypass;

endmodule
